// File: rtl/lut_pkg.sv
// Shared definitions for the run-time programmable key->data lookup table.
package lut_pkg;

  // Table operation encoding on wr_op
  localparam logic OP_DEL = 1'b0;
  localparam logic OP_INS = 1'b1;

  // Writer FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Width of one {key,data} slot on the lut bus
  function automatic int pair_len(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

  // Width of a slot index; never below one bit so single-slot tables still elaborate
  function automatic int idx_w(input int nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

endpackage

// File: rtl/lut_match.sv
// Parallel compare of a probe against every table entry, gated by entry valid.
// Produces the lowest-index match as a one-hot vector and as a binary index.
module lut_match
  import lut_pkg::*;
#(
  parameter int NR_KEY = 4,
  parameter int W      = 4
) (
  input  logic [W-1:0]                probe_i,
  input  logic [NR_KEY*W-1:0]         entries_i,
  input  logic [NR_KEY-1:0]           valid_i,
  output logic [NR_KEY-1:0]           hit_o,
  output logic                        any_hit_o,
  output logic [idx_w(NR_KEY)-1:0]    idx_o
);

  localparam int IW = idx_w(NR_KEY);

  logic [NR_KEY-1:0] raw_hit;

  // Compare every valid entry and encode the lowest matching slot
  always_comb begin
    raw_hit = '0;
    idx_o   = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      raw_hit[n] = valid_i[n] && (entries_i[n*W +: W] == probe_i);
    end
    for (int n = NR_KEY - 1; n >= 0; n--) begin
      if (raw_hit[n]) idx_o = IW'(n);
    end
  end

  // Isolate the lowest set bit so the vector stays one-hot even for duplicate data
  assign hit_o     = raw_hit & (~raw_hit + 1'b1);
  assign any_hit_o = |raw_hit;

endmodule

// File: rtl/lut_table_writer.sv
// Owns a key->data table, applies insert/update/delete/clear ops from the
// config side, drives the packed lut bus for MuxKey readers, and answers
// registered reverse (data->key) queries.
module lut_table_writer
  import lut_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic                                  wr_op,
  input  logic [KEY_LEN-1:0]                    wr_key,
  input  logic [DATA_LEN-1:0]                   wr_data,
  input  logic                                  clr,
  output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic [NR_KEY-1:0]                     entry_valid,
  output logic [$clog2(NR_KEY+1)-1:0]           count,
  output logic                                  full,
  input  logic                                  rev_req,
  input  logic [DATA_LEN-1:0]                   rev_data,
  output logic                                  rev_resp_valid,
  output logic                                  rev_hit,
  output logic [KEY_LEN-1:0]                    rev_key
);

  localparam int PAIR = pair_len(KEY_LEN, DATA_LEN);
  localparam int IW   = idx_w(NR_KEY);
  localparam int CW   = $clog2(NR_KEY + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NR_KEY - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NR_KEY);

  state_e              state_q;
  logic [IW-1:0]       clr_idx_q;
  logic [IW-1:0]       ptr_q;
  logic [CW-1:0]       count_q;
  logic [NR_KEY-1:0]   valid_q;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic                rev_resp_valid_q;
  logic                rev_hit_q;
  logic [KEY_LEN-1:0]  rev_key_q;

  logic [NR_KEY*KEY_LEN-1:0]  key_flat;
  logic [NR_KEY*DATA_LEN-1:0] data_flat;

  logic [NR_KEY-1:0] key_oh, data_oh, free_oh;
  logic              key_any, data_any, free_any;
  logic [IW-1:0]     key_idx, data_idx, free_idx;
  logic              wr_accept;

  // Only the binary index and any-hit flags steer the table here
  logic unused;
  assign unused = ^{key_oh, data_oh, free_oh};

  // Flatten slot registers for the matchers and build the lut bus; invalid slots hold zero
  always_comb begin
    key_flat  = '0;
    data_flat = '0;
    lut       = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      key_flat[n*KEY_LEN +: KEY_LEN]   = key_q[n];
      data_flat[n*DATA_LEN +: DATA_LEN] = data_q[n];
      lut[n*PAIR +: PAIR]              = {key_q[n], data_q[n]};
    end
  end

  // Existing-key lookup for update/delete
  lut_match #(.NR_KEY(NR_KEY), .W(KEY_LEN)) u_key_match (
    .probe_i   (wr_key),
    .entries_i (key_flat),
    .valid_i   (valid_q),
    .hit_o     (key_oh),
    .any_hit_o (key_any),
    .idx_o     (key_idx)
  );

  // Reverse lookup against the pre-write table contents
  lut_match #(.NR_KEY(NR_KEY), .W(DATA_LEN)) u_data_match (
    .probe_i   (rev_data),
    .entries_i (data_flat),
    .valid_i   (valid_q),
    .hit_o     (data_oh),
    .any_hit_o (data_any),
    .idx_o     (data_idx)
  );

  // Lowest free slot: every entry matches a zero probe, gated by "slot is invalid"
  lut_match #(.NR_KEY(NR_KEY), .W(1)) u_free_find (
    .probe_i   (1'b0),
    .entries_i ({NR_KEY{1'b0}}),
    .valid_i   (~valid_q),
    .hit_o     (free_oh),
    .any_hit_o (free_any),
    .idx_o     (free_idx)
  );

  // Ready is purely a function of state; a same-cycle clr still cancels the op
  assign wr_ready  = (state_q == ST_IDLE);
  assign wr_accept = wr_valid && wr_ready && !clr;

  // Writer FSM, table storage and registered reverse-lookup response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      clr_idx_q        <= '0;
      ptr_q            <= '0;
      count_q          <= '0;
      valid_q          <= '0;
      rev_resp_valid_q <= 1'b0;
      rev_hit_q        <= 1'b0;
      rev_key_q        <= '0;
      for (int n = 0; n < NR_KEY; n++) begin
        key_q[n]  <= '0;
        data_q[n] <= '0;
      end
    end else begin
      rev_resp_valid_q <= rev_req;
      rev_hit_q        <= rev_req && data_any;
      rev_key_q        <= (rev_req && data_any) ? key_q[data_idx] : '0;

      case (state_q)
        ST_IDLE: begin
          if (clr) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
          end else if (wr_accept) begin
            if (wr_op == OP_INS) begin
              if (key_any) begin
                data_q[key_idx] <= wr_data;
              end else if (free_any) begin
                valid_q[free_idx] <= 1'b1;
                key_q[free_idx]   <= wr_key;
                data_q[free_idx]  <= wr_data;
                count_q           <= count_q + 1'b1;
              end else begin
                key_q[ptr_q]  <= wr_key;
                data_q[ptr_q] <= wr_data;
                ptr_q         <= (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
              end
            end else if (key_any) begin
              valid_q[key_idx] <= 1'b0;
              key_q[key_idx]   <= '0;
              data_q[key_idx]  <= '0;
              count_q          <= count_q - 1'b1;
            end
          end
        end

        ST_CLEAR: begin
          if (valid_q[clr_idx_q]) count_q <= count_q - 1'b1;
          valid_q[clr_idx_q] <= 1'b0;
          key_q[clr_idx_q]   <= '0;
          data_q[clr_idx_q]  <= '0;
          if (clr_idx_q == LAST_IDX) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
            ptr_q     <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign entry_valid    = valid_q;
  assign count          = count_q;
  assign full           = (count_q == FULL_CNT);
  assign rev_resp_valid = rev_resp_valid_q;
  assign rev_hit        = rev_hit_q;
  assign rev_key        = rev_key_q;

endmodule

// File: tb/tb_lut_table_writer.sv
// Bench for lut_table_writer: constant-expectation vector table for the
// directed insert/update/replace/delete flow, hand sequences for clear,
// reverse lookup and reset, then random traffic against a slot-table model.
module tb_lut_table_writer;

  localparam int NK = 4;
  localparam int KL = 4;
  localparam int DL = 8;
  localparam int PL = KL + DL;
  localparam int CW = $clog2(NK + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic wr_valid, wr_op, clr, rev_req;
  logic [KL-1:0] wr_key;
  logic [DL-1:0] wr_data, rev_data;
  logic wr_ready, full, rev_resp_valid, rev_hit;
  logic [NK*PL-1:0] lut;
  logic [NK-1:0] entry_valid;
  logic [CW-1:0] count;
  logic [KL-1:0] rev_key;

  lut_table_writer #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_op(wr_op), .wr_key(wr_key), .wr_data(wr_data), .clr(clr),
    .lut(lut), .entry_valid(entry_valid), .count(count), .full(full),
    .rev_req(rev_req), .rev_data(rev_data), .rev_resp_valid(rev_resp_valid),
    .rev_hit(rev_hit), .rev_key(rev_key)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference table: slot contents, replacement pointer, clear progress (-1 = not clearing)
  logic [KL-1:0] m_k [NK];
  logic [DL-1:0] m_d [NK];
  bit            m_v [NK];
  int            m_ptr;
  int            clr_pos;
  bit            e_rv, e_rh;
  logic [KL-1:0] e_rk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NK; n++) begin
      m_k[n] = '0; m_d[n] = '0; m_v[n] = 1'b0;
    end
    m_ptr = 0; clr_pos = -1; e_rv = 0; e_rh = 0; e_rk = '0;
  endtask

  function automatic int find_key(input logic [KL-1:0] k);
    for (int n = 0; n < NK; n++) if (m_v[n] && m_k[n] == k) return n;
    return -1;
  endfunction

  function automatic int find_free();
    for (int n = 0; n < NK; n++) if (!m_v[n]) return n;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int n = 0; n < NK; n++) c += int'(m_v[n]);
    return c;
  endfunction

  function automatic logic [NK*PL-1:0] m_lut();
    logic [NK*PL-1:0] r = '0;
    for (int n = 0; n < NK; n++) if (m_v[n]) r[n*PL +: PL] = {m_k[n], m_d[n]};
    return r;
  endfunction

  function automatic logic [NK-1:0] m_valid();
    logic [NK-1:0] r = '0;
    for (int n = 0; n < NK; n++) r[n] = m_v[n];
    return r;
  endfunction

  // Consumer view: OR of the data of every slot whose key matches
  function automatic logic [DL-1:0] muxkey(input logic [NK*PL-1:0] bus, input logic [KL-1:0] k);
    logic [DL-1:0] r = '0;
    for (int n = 0; n < NK; n++) if (bus[n*PL+DL +: KL] == k) r |= bus[n*PL +: DL];
    return r;
  endfunction

  // Advance the reference by one clock using the inputs currently driven
  task automatic model_step();
    int s;
    e_rv = rev_req; e_rh = 0; e_rk = '0;
    if (rev_req) begin
      for (int n = 0; n < NK; n++) begin
        if (m_v[n] && m_d[n] == rev_data) begin
          e_rh = 1; e_rk = m_k[n]; break;
        end
      end
    end
    if (clr_pos >= 0) begin
      m_v[clr_pos] = 0; m_k[clr_pos] = '0; m_d[clr_pos] = '0;
      clr_pos++;
      if (clr_pos == NK) begin clr_pos = -1; m_ptr = 0; end
    end else if (clr) begin
      clr_pos = 0;
    end else if (wr_valid) begin
      s = find_key(wr_key);
      if (wr_op) begin
        if (s >= 0) m_d[s] = wr_data;
        else if (find_free() >= 0) begin
          s = find_free(); m_v[s] = 1; m_k[s] = wr_key; m_d[s] = wr_data;
        end else begin
          m_k[m_ptr] = wr_key; m_d[m_ptr] = wr_data; m_ptr = (m_ptr + 1) % NK;
        end
      end else if (s >= 0) begin
        m_v[s] = 0; m_k[s] = '0; m_d[s] = '0;
      end
    end
  endtask

  task automatic check_all();
    check("lut", 64'(lut), 64'(m_lut()));
    check("entry_valid", 64'(entry_valid), 64'(m_valid()));
    check("count", 64'(count), 64'(m_count()));
    check("full", 64'(full), 64'(m_count() == NK));
    check("wr_ready", 64'(wr_ready), 64'(clr_pos < 0));
    check("rev_resp_valid", 64'(rev_resp_valid), 64'(e_rv));
    if (e_rv) begin
      check("rev_hit", 64'(rev_hit), 64'(e_rh));
      check("rev_key", 64'(rev_key), 64'(e_rk));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle_in();
    wr_valid = 0; wr_op = 0; wr_key = '0; wr_data = '0; clr = 0; rev_req = 0; rev_data = '0;
  endtask

  task automatic put(input logic op, input logic [KL-1:0] k, input logic [DL-1:0] d);
    wr_valid = 1; wr_op = op; wr_key = k; wr_data = d;
  endtask

  typedef struct {
    logic          op;
    logic [KL-1:0] key;
    logic [DL-1:0] data;
    logic [47:0]   lut;
    logic [3:0]    vld;
    int            cnt;
  } vec_t;

  vec_t tv [14];

  initial begin
    tv[0]  = '{1'b1, 4'h3, 8'hA5, 48'h000_000_000_3A5, 4'b0001, 1};
    tv[1]  = '{1'b1, 4'h3, 8'h5A, 48'h000_000_000_35A, 4'b0001, 1};
    tv[2]  = '{1'b1, 4'h1, 8'h11, 48'h000_000_111_35A, 4'b0011, 2};
    tv[3]  = '{1'b1, 4'h2, 8'h22, 48'h000_222_111_35A, 4'b0111, 3};
    tv[4]  = '{1'b1, 4'h4, 8'h44, 48'h444_222_111_35A, 4'b1111, 4};
    tv[5]  = '{1'b1, 4'h7, 8'h77, 48'h444_222_111_777, 4'b1111, 4};
    tv[6]  = '{1'b1, 4'h8, 8'h88, 48'h444_222_888_777, 4'b1111, 4};
    tv[7]  = '{1'b0, 4'h4, 8'h00, 48'h000_222_888_777, 4'b0111, 3};
    tv[8]  = '{1'b0, 4'h9, 8'h00, 48'h000_222_888_777, 4'b0111, 3};
    tv[9]  = '{1'b1, 4'h9, 8'h99, 48'h999_222_888_777, 4'b1111, 4};
    tv[10] = '{1'b1, 4'hA, 8'hAA, 48'h999_AAA_888_777, 4'b1111, 4};
    tv[11] = '{1'b1, 4'h8, 8'h5C, 48'h999_AAA_85C_777, 4'b1111, 4};
    tv[12] = '{1'b1, 4'hB, 8'hBB, 48'hBBB_AAA_85C_777, 4'b1111, 4};
    tv[13] = '{1'b1, 4'hC, 8'hCC, 48'hBBB_AAA_85C_CCC, 4'b1111, 4};

    idle_in();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_lut", 64'(lut), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_ready", 64'(wr_ready), 64'h1);
    check_all();
    rst_n = 1;

    // Directed insert / update / replace / delete vectors
    for (int i = 0; i < 14; i++) begin
      check("tv_ready_pre", 64'(wr_ready), 64'h1);
      put(tv[i].op, tv[i].key, tv[i].data);
      cycle();
      idle_in();
      check($sformatf("tv%0d_lut", i), 64'(lut), 64'(tv[i].lut));
      check($sformatf("tv%0d_valid", i), 64'(entry_valid), 64'(tv[i].vld));
      check($sformatf("tv%0d_count", i), 64'(count), 64'(tv[i].cnt));
      check($sformatf("tv%0d_full", i), 64'(full), 64'(tv[i].cnt == NK));
      if (i == 1) check("muxkey_k3", 64'(muxkey(lut, 4'h3)), 64'h5A);
    end

    // Clear together with a write: write dropped, ready low for exactly NK cycles
    clr = 1; put(1'b1, 4'hD, 8'hDD);
    cycle();
    idle_in();
    check("clr_drop_lut", 64'(lut), 64'hBBB_AAA_85C_CCC);
    check("clr_ready_c1", 64'(wr_ready), 64'h0);
    clr = 1;                               // re-pulse while clearing: ignored
    cycle();
    clr = 0;
    check("clr_ready_c2", 64'(wr_ready), 64'h0);
    rev_req = 1; rev_data = 8'h5C;         // slot0 gone, slot1 still present
    cycle();
    check("clr_rev_hit", 64'(rev_hit), 64'h1);
    check("clr_rev_key", 64'(rev_key), 64'h8);
    check("clr_ready_c3", 64'(wr_ready), 64'h0);
    cycle();                               // back-to-back: slot1 now cleared
    rev_req = 0;
    check("clr_rev2_valid", 64'(rev_resp_valid), 64'h1);
    check("clr_rev2_hit", 64'(rev_hit), 64'h0);
    check("clr_rev2_key", 64'(rev_key), 64'h0);
    check("clr_ready_c4", 64'(wr_ready), 64'h0);
    cycle();
    check("clr_done_ready", 64'(wr_ready), 64'h1);
    check("clr_done_lut", 64'(lut), 64'h0);
    check("clr_done_count", 64'(count), 64'h0);

    // Reverse lookup sees pre-write state; lowest index wins
    put(1'b1, 4'h1, 8'hA5); cycle();
    put(1'b1, 4'h2, 8'hA5); cycle();
    put(1'b1, 4'h1, 8'h00); rev_req = 1; rev_data = 8'hA5;
    cycle();
    idle_in();
    check("rev_hit", 64'(rev_hit), 64'h1);
    check("rev_key_lowest", 64'(rev_key), 64'h1);
    check("rev_wr_lut", 64'(lut), 64'h000_000_2A5_100);
    rev_req = 1; rev_data = 8'hA5;
    cycle();
    idle_in();
    check("rev_key_after_wr", 64'(rev_key), 64'h2);

    // Victim pointer restarts at slot 0 after a clear
    put(1'b1, 4'h3, 8'h33); cycle();
    put(1'b1, 4'h4, 8'h44); cycle();
    put(1'b1, 4'h5, 8'h55); cycle();
    idle_in();
    check("ptr_reset_lut", 64'(lut), 64'h444_333_2A5_555);

    // Asynchronous reset in the middle of an accepted insert and a reverse request
    put(1'b1, 4'h6, 8'h66); rev_req = 1; rev_data = 8'h33;
    #3 rst_n = 0;
    @(posedge clk); #1;
    idle_in();
    model_reset();
    check("rstmid_lut", 64'(lut), 64'h0);
    check("rstmid_valid", 64'(entry_valid), 64'h0);
    check("rstmid_rvalid", 64'(rev_resp_valid), 64'h0);
    check("rstmid_rhit", 64'(rev_hit), 64'h0);
    check("rstmid_rkey", 64'(rev_key), 64'h0);
    check_all();
    rst_n = 1;

    // Random traffic against the reference table
    for (int i = 0; i < 600; i++) begin
      clr      = ($urandom_range(0, 40) == 0);
      wr_valid = $urandom_range(0, 1) == 1;
      wr_op    = $urandom_range(0, 3) != 0;
      wr_key   = KL'($urandom_range(0, 7));
      wr_data  = {4'($urandom_range(0, 3)), 4'h5};
      rev_req  = $urandom_range(0, 1) == 1;
      rev_data = {4'($urandom_range(0, 3)), 4'h5};
      cycle();
    end
    idle_in();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
